// File: rtl/pipe_pkg.sv
// Shared types and per-stage default widths for the pipeline stage registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam int IF_ID_CTRL_W  = 8;
    localparam int IF_ID_DATA_W  = 96;
    localparam int ID_EX_CTRL_W  = 16;
    localparam int ID_EX_DATA_W  = 192;
    localparam int EX_MEM_CTRL_W = 12;
    localparam int EX_MEM_DATA_W = 128;
    localparam int MEM_WB_CTRL_W = 6;
    localparam int MEM_WB_DATA_W = 72;

    localparam int PIPE_CTRL_MAX_W = 64;

    // Value driven on the control bundle whenever a stage holds no beat.
    function automatic logic [PIPE_CTRL_MAX_W-1:0] pipe_ctrl_zero();
        return '0;
    endfunction

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating up-counter with enable; counts back-pressure cycles of a stage.
module pipe_stall_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with a two-entry skid store and flush.
// Define PIPE_STAGE_PERF_EN to build the saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 192,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_t       state;
    pipe_state_t       state_next;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              in_fire;
    logic              out_fire;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;

    // Both handshake signals come straight from the state register, so there
    // is no combinational path from out_ready or in_* to any output.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign out_ctrl  = out_valid ? main_ctrl : CTRL_W'(pipe_ctrl_zero());
    assign out_data  = main_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is given a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_next   = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_next     = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Flush wins over every transition and drops any beat offered with it.
        if (flush) begin
            state_next     = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // NOTE: the bundle registers are reset as well, because out_data must read
    // zero straight out of reset; flush leaves them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            if (load_main_in) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
            end else if (load_main_skid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    pipe_stall_counter #(
        .CNT_W(CNT_W)
    ) u_stall_counter (
        .clk  (clk),
        .rst  (rst),
        .en   (out_valid & ~out_ready),
        .count(stall_cnt)
    );
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed stimulus, decoupled output monitor.
module tb_pipe_stage_reg;

    localparam int CTRL_W = 8;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;
`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    int    checks   = 0;
    int    failures = 0;
    beat_t sb[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .stall_cnt(stall_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: a beat leaves at the next edge whenever out_valid & out_ready.
    always @(negedge clk) begin
        if (!rst) begin
            if (!out_valid) begin
                check("idle_ctrl_zero", 32'(out_ctrl), 32'd0);
            end else if (out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 32'(out_ctrl), 32'hFFFF_FFFF);
                end else begin
                    beat_t exp_beat;
                    exp_beat = sb.pop_front();
                    check("beat_ctrl", 32'(out_ctrl), 32'(exp_beat.ctrl));
                    check("beat_data", 32'(out_data), 32'(exp_beat.data));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    task automatic send(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        drive(1'b1, c, d);
        sb.push_back('{ctrl: c, data: d});
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_ctrl", 32'(out_ctrl), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);

        // Stream eight beats at full rate.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(CTRL_W'(i + 1), DATA_W'(16'h10 + i));
            check("stream_in_ready", 32'(in_ready), 32'd1);
            step();
        end
        drive(1'b0, '0, '0);
        step();
        check("stream_drained", 32'(out_valid), 32'd0);
        check("stream_stall", 32'(stall_cnt), 32'd0);

        // Back-pressure: A accepted, B fills skid, C held off until release.
        do_reset();
        send(8'hA1, 16'hAAAA);
        step();
        send(8'hB2, 16'hBBBB);
        check("bp_ready_skid_fill", 32'(in_ready), 32'd1);
        step();
        drive(1'b1, 8'hC3, 16'hCCCC);
        check("bp_ready_c1", 32'(in_ready), 32'd0);
        step();
        check("bp_ready_c2", 32'(in_ready), 32'd0);
        step();
        check("bp_stall", 32'(stall_cnt), PERF ? 32'd3 : 32'd0);
        out_ready = 1'b1;
        check("bp_ready_release", 32'(in_ready), 32'd0);
        step();
        check("bp_ready_after", 32'(in_ready), 32'd1);
        sb.push_back('{ctrl: 8'hC3, data: 16'hCCCC});
        step();
        drive(1'b0, '0, '0);
        step();
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_stall_hold", 32'(stall_cnt), PERF ? 32'd3 : 32'd0);

        // Flush while FULL, with C offered in the same cycle.
        do_reset();
        send(8'h11, 16'h1111);
        step();
        send(8'h22, 16'h2222);
        step();
        drive(1'b1, 8'h33, 16'h3333);
        flush = 1'b1;
        check("fl_full_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        sb.delete();
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_out_ctrl", 32'(out_ctrl), 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd1);
        check("fl_data_kept", 32'(out_data), 32'h1111);
        out_ready = 1'b1;
        repeat (3) step();
        send(8'h44, 16'h4444);
        step();
        drive(1'b0, '0, '0);
        step();
        check("fl_recover", 32'(out_valid), 32'd0);

        // Saturation over 20 stalled cycles, then flush must not clear it.
        do_reset();
        send(8'h55, 16'h5555);
        step();
        drive(1'b0, '0, '0);
        repeat (20) step();
        check("sat_stall", 32'(stall_cnt), PERF ? 32'd15 : 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        sb.delete();
        check("sat_after_flush", 32'(stall_cnt), PERF ? 32'd15 : 32'd0);
        check("sat_flush_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset asserted between edges.
        do_reset();
        send(8'h5A, 16'hA5A5);
        step();
        send(8'h6B, 16'hB6B6);
        step();
        drive(1'b0, '0, '0);
        check("ar_pre_valid", 32'(out_valid), 32'd1);
        check("ar_pre_stall", 32'(stall_cnt), PERF ? 32'd1 : 32'd0);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_out_ctrl", 32'(out_ctrl), 32'd0);
        check("ar_out_data", 32'(out_data), 32'd0);
        check("ar_stall", 32'(stall_cnt), 32'd0);
        check("ar_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(8'h77, 16'h7777);
        step();
        drive(1'b0, '0, '0);
        step();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
